// File: rtl/definitions_pkg.sv
// Shared record types for the instruction-fetch path; the upstream FIFO
// and the read issuer both carry InstructionRead entries.
package definitions_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [15:0] length;
        logic [7:0]  tag;
    } InstructionRead;

    localparam int INSTR_READ_W = $bits(InstructionRead);

endpackage

// File: rtl/outstanding_counter.sv
// Tracks bursts accepted by memory that still await their mem_rsp_last,
// with a sticky flag for completions that arrive when nothing is pending.
module outstanding_counter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             underflow
);

    always_ff @(posedge clk) begin
        if (srst) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10: count <= count + 1'b1;
                2'b01: begin
                    if (count == '0) underflow <= 1'b1;
                    else             count     <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign full = (count == CNT_W'(MAX_OUTSTANDING));

endmodule

// File: rtl/instr_read_issuer.sv
// Pops InstructionRead entries and splits each into memory bursts of at most
// MAX_BURST words, throttled by the number of bursts still in flight.
module instr_read_issuer
    import definitions_pkg::*;
#(
    parameter int ADDR_W          = 32,
    parameter int MAX_BURST       = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int WORD_BYTES      = 4
) (
    input  logic              clk,
    input  logic              srst,
    input  InstructionRead    fifo_dout,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [7:0]        mem_req_len,
    output logic [7:0]        mem_req_tag,
    input  logic              mem_rsp_last,
    output logic              done_valid,
    output logic [7:0]        done_tag,
    output logic              busy,
    output logic              err_underflow
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {IDLE, POP_WAIT, ISSUE} state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [7:0]        tag;
    logic [7:0]        burst_len;
    logic              accept;
    logic              last_accept;
    logic [CNT_W-1:0]  outstanding;
    logic              full;

    assign burst_len   = (remaining > 16'(MAX_BURST)) ? 8'(MAX_BURST) : remaining[7:0];
    assign accept      = mem_req_valid & mem_req_ready;
    assign last_accept = accept && (remaining == 16'(burst_len));

    always_ff @(posedge clk) begin
        if (srst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (!fifo_empty) state_next = POP_WAIT;
            POP_WAIT: state_next = (fifo_dout.length == 16'd0) ? IDLE : ISSUE;
            ISSUE:    if (last_accept) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_rd_en    = (state == IDLE) && !fifo_empty;
        mem_req_valid = (state == ISSUE) && !full;
    end

    // Entry registers only move on capture or accept, which keeps the request stable under backpressure.
    always_ff @(posedge clk) begin
        if (srst) begin
            addr       <= '0;
            remaining  <= '0;
            tag        <= '0;
            done_valid <= 1'b0;
            done_tag   <= '0;
        end else begin
            done_valid <= 1'b0;
            if (state == POP_WAIT) begin
                addr      <= ADDR_W'(fifo_dout.addr);
                remaining <= fifo_dout.length;
                tag       <= fifo_dout.tag;
                if (fifo_dout.length == 16'd0) begin
                    done_valid <= 1'b1;
                    done_tag   <= fifo_dout.tag;
                end
            end else if (accept) begin
                remaining <= remaining - 16'(burst_len);
                addr      <= addr + ADDR_W'(burst_len) * ADDR_W'(WORD_BYTES);
                if (last_accept) begin
                    done_valid <= 1'b1;
                    done_tag   <= tag;
                end
            end
        end
    end

    outstanding_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_outstanding (
        .clk      (clk),
        .srst     (srst),
        .inc      (accept),
        .dec      (mem_rsp_last),
        .count    (outstanding),
        .full     (full),
        .underflow(err_underflow)
    );

    assign mem_req_addr = addr;
    assign mem_req_len  = burst_len;
    assign mem_req_tag  = tag;
    assign busy         = (state != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_instr_read_issuer.sv
// Directed bench for instr_read_issuer: a vector table of single entries
// plus hand-written sequences for backpressure, throttling and reset.
module tb_instr_read_issuer;
    import definitions_pkg::*;

    logic           clk = 1'b0;
    logic           srst = 1'b1;
    InstructionRead fifo_dout = '0;
    logic           fifo_empty;
    logic           fifo_rd_en;
    logic           mem_req_valid;
    logic           mem_req_ready = 1'b1;
    logic [31:0]    mem_req_addr;
    logic [7:0]     mem_req_len;
    logic [7:0]     mem_req_tag;
    logic           mem_rsp_last;
    logic           done_valid;
    logic [7:0]     done_tag;
    logic           busy;
    logic           err_underflow;

    logic auto_rsp = 1'b1;
    logic man_rsp  = 1'b0;
    logic acc_d    = 1'b0;

    int total = 0;
    int bad   = 0;

    instr_read_issuer #(
        .ADDR_W(32), .MAX_BURST(16), .MAX_OUTSTANDING(4), .WORD_BYTES(4)
    ) dut (
        .clk(clk), .srst(srst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_len(mem_req_len), .mem_req_tag(mem_req_tag),
        .mem_rsp_last(mem_rsp_last), .done_valid(done_valid), .done_tag(done_tag),
        .busy(busy), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model with one-cycle read latency, flushed by srst.
    InstructionRead fifo_mem [16];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign mem_rsp_last = auto_rsp ? acc_d : man_rsp;

    always @(posedge clk) begin
        if (srst) rd_ptr <= wr_ptr;
        else if (fifo_rd_en) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 4'd1;
        end
    end

    // Observation log
    int          cyc = 0;
    int          acc_cnt = 0;
    int          last_acc_cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          rd_cyc = 0;
    logic [7:0]  done_tag_seen = 8'd0;
    logic [31:0] acc_addr [256];
    logic [7:0]  acc_len  [256];
    logic [7:0]  acc_tag  [256];

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        acc_d <= mem_req_valid & mem_req_ready;
        if (mem_req_valid && mem_req_ready) begin
            acc_addr[acc_cnt % 256] <= mem_req_addr;
            acc_len[acc_cnt % 256]  <= mem_req_len;
            acc_tag[acc_cnt % 256]  <= mem_req_tag;
            acc_cnt      <= acc_cnt + 1;
            last_acc_cyc <= cyc;
        end
        if (done_valid) begin
            done_cnt      <= done_cnt + 1;
            done_tag_seen <= done_tag;
            done_cyc      <= cyc;
        end
        if (fifo_rd_en) rd_cyc <= cyc;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [15:0] l, input logic [7:0] t);
        fifo_mem[wr_ptr] = '{addr: a, length: l, tag: t};
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic wait_done(input int d0);
        int n = 0;
        while (done_cnt == d0 && n < 200) begin
            step();
            n++;
        end
        chk("done_timeout", 64'(done_cnt != d0), 64'd1);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [15:0] len;
        logic [7:0]  tag;
        int          bursts;
        logic [31:0] last_addr;
        logic [7:0]  last_len;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int a0;
        int d0;
        int n;
        int li;

        vecs[0] = '{32'h0000_1000, 16'd40, 8'd7, 3, 32'h0000_1080, 8'd8};
        vecs[1] = '{32'h0000_2000, 16'd16, 8'd1, 1, 32'h0000_2000, 8'd16};
        vecs[2] = '{32'h0000_3000, 16'd17, 8'd2, 2, 32'h0000_3040, 8'd1};
        vecs[3] = '{32'h0000_0000, 16'd1,  8'd9, 1, 32'h0000_0000, 8'd1};
        vecs[4] = '{32'hFFFF_FFC0, 16'd20, 8'd8, 2, 32'h0000_0000, 8'd4};
        vecs[5] = '{32'h0000_4000, 16'd48, 8'd5, 3, 32'h0000_4080, 8'd16};

        srst = 1'b1;
        step();
        step();
        chk("reset_ctrl", {60'd0, fifo_rd_en, mem_req_valid, done_valid, busy}, 64'd0);
        chk("reset_req", {24'd0, mem_req_addr, mem_req_len}, 64'd0);
        chk("reset_tags", {48'd0, mem_req_tag, done_tag}, 64'd0);
        chk("reset_err", 64'(err_underflow), 64'd0);
        srst = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            a0 = acc_cnt;
            d0 = done_cnt;
            push(vecs[i].addr, vecs[i].len, vecs[i].tag);
            wait_done(d0);
            li = (acc_cnt - 1) % 256;
            chk($sformatf("v%0d_bursts", i), 64'(acc_cnt - a0), 64'(vecs[i].bursts));
            chk($sformatf("v%0d_first_addr", i), 64'(acc_addr[a0 % 256]), 64'(vecs[i].addr));
            chk($sformatf("v%0d_first_len", i), 64'(acc_len[a0 % 256]),
                (vecs[i].len > 16'd16) ? 64'd16 : 64'(vecs[i].len));
            chk($sformatf("v%0d_last_addr", i), 64'(acc_addr[li]), 64'(vecs[i].last_addr));
            chk($sformatf("v%0d_last_len", i), 64'(acc_len[li]), 64'(vecs[i].last_len));
            chk($sformatf("v%0d_req_tag", i), 64'(acc_tag[li]), 64'(vecs[i].tag));
            chk($sformatf("v%0d_done_tag", i), 64'(done_tag_seen), 64'(vecs[i].tag));
            chk($sformatf("v%0d_done_lat", i), 64'(done_cyc - last_acc_cyc), 64'd1);
            step();
            step();
        end

        // Zero-length entry
        a0 = acc_cnt;
        d0 = done_cnt;
        push(32'h0000_5000, 16'd0, 8'd3);
        wait_done(d0);
        chk("len0_no_req", 64'(acc_cnt - a0), 64'd0);
        chk("len0_done_tag", 64'(done_tag_seen), 64'd3);
        chk("len0_done_lat", 64'(done_cyc - rd_cyc), 64'd2);
        step();
        chk("len0_done_pulse", 64'(done_valid), 64'd0);

        // Outstanding limit without completions
        auto_rsp = 1'b0;
        a0 = acc_cnt;
        d0 = done_cnt;
        push(32'h0000_8000, 16'd100, 8'd4);
        repeat (12) step();
        chk("thr_accepts", 64'(acc_cnt - a0), 64'd4);
        chk("thr_valid_low", 64'(mem_req_valid), 64'd0);
        chk("thr_busy", 64'(busy), 64'd1);
        man_rsp = 1'b1;
        step();
        man_rsp = 1'b0;
        chk("thr_fifth", {23'd0, mem_req_valid, mem_req_addr, mem_req_len}, {23'd0, 1'b1, 32'h0000_8100, 8'd16});
        repeat (6) begin
            step();
            man_rsp = 1'b1;
            step();
            man_rsp = 1'b0;
            step();
        end
        li = (acc_cnt - 1) % 256;
        chk("thr_total", 64'(acc_cnt - a0), 64'd7);
        chk("thr_last", {24'd0, acc_addr[li], acc_len[li]}, {24'd0, 32'h0000_8180, 8'd4});
        chk("thr_done", {56'(done_cnt - d0), done_tag_seen}, {56'd1, 8'd4});
        chk("thr_idle", {62'd0, busy, err_underflow}, 64'd0);
        auto_rsp = 1'b1;

        // Backpressure hold
        mem_req_ready = 1'b0;
        d0 = done_cnt;
        push(32'h0000_9000, 16'd20, 8'd6);
        n = 0;
        while (!mem_req_valid && n < 20) begin
            step();
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("bp_hold%0d", i), {15'd0, mem_req_valid, mem_req_addr, mem_req_len, mem_req_tag},
                {15'd0, 1'b1, 32'h0000_9000, 8'd16, 8'd6});
            step();
        end
        a0 = acc_cnt;
        mem_req_ready = 1'b1;
        wait_done(d0);
        li = (acc_cnt - 1) % 256;
        chk("bp_bursts", 64'(acc_cnt - a0), 64'd2);
        chk("bp_last", {24'd0, acc_addr[li], acc_len[li]}, {24'd0, 32'h0000_9040, 8'd4});
        step();
        step();

        // Reset mid-burst, then completion with nothing pending
        auto_rsp = 1'b0;
        a0 = acc_cnt;
        d0 = done_cnt;
        push(32'h0000_A000, 16'd100, 8'd2);
        n = 0;
        while ((acc_cnt - a0) < 2 && n < 20) begin
            step();
            n++;
        end
        mem_req_ready = 1'b0;
        chk("rst_pre_busy", 64'(busy), 64'd1);
        srst = 1'b1;
        step();
        srst = 1'b0;
        chk("rst_mid_ctrl", {60'd0, fifo_rd_en, mem_req_valid, done_valid, busy}, 64'd0);
        chk("rst_mid_req", {8'd0, mem_req_addr, mem_req_len, mem_req_tag}, 64'd0);
        chk("rst_mid_done_tag", 64'(done_tag), 64'd0);
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        chk("rst_mid_err", 64'(err_underflow), 64'd0);
        man_rsp = 1'b1;
        step();
        man_rsp = 1'b0;
        chk("underflow_set", 64'(err_underflow), 64'd1);
        step();
        chk("underflow_sticky", {62'd0, err_underflow, busy}, {62'd0, 1'b1, 1'b0});
        mem_req_ready = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
